// File: rtl/ahb_sram_pkg.sv
// Shared definitions for the AHB-lite to DFFRAM bridge: bus encodings,
// controller states and byte-lane decode.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REREAD = 2'd2
    } state_t;

    // Byte enables for an access; any size above word is handled as a word.
    function automatic logic [3:0] lanes(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (hsize)
            3'd0:    be = 4'b0001 << addr_lo;
            3'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted write buffer: holds a write that lost the SRAM port,
// compares its word address against an incoming read, and overlays its
// bytes onto SRAM read data when forwarding is enabled.
module ahb_sram_wbuf #(
    parameter int AW = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          store_i,
    input  logic          drain_i,
    input  logic [AW-1:0] st_addr_i,
    input  logic [3:0]    st_lanes_i,
    input  logic [31:0]   st_data_i,
    input  logic [AW-1:0] cmp_addr_i,
    input  logic          merge_en_i,
    input  logic [31:0]   rdata_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [3:0]    lanes_o,
    output logic [31:0]   data_o,
    output logic          hit_o,
    output logic [31:0]   merge_o
);

    logic          buf_v_q;
    logic [AW-1:0] buf_addr_q;
    logic [3:0]    buf_lanes_q;
    logic [31:0]   buf_data_q;

    // A store takes precedence over a drain in the same cycle: the drained
    // entry is leaving through the SRAM port while the new one replaces it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_v_q     <= 1'b0;
            buf_addr_q  <= '0;
            buf_lanes_q <= '0;
            buf_data_q  <= '0;
        end else if (store_i) begin
            buf_v_q     <= 1'b1;
            buf_addr_q  <= st_addr_i;
            buf_lanes_q <= st_lanes_i;
            buf_data_q  <= st_data_i;
        end else if (drain_i) begin
            buf_v_q     <= 1'b0;
        end
    end

    assign valid_o = buf_v_q;
    assign addr_o  = buf_addr_q;
    assign lanes_o = buf_lanes_q;
    assign data_o  = buf_data_q;
    assign hit_o   = buf_v_q && (buf_addr_q == cmp_addr_i);

    // Buffered bytes override SRAM bytes on the lanes the buffered write touches.
    always_comb begin
        merge_o = rdata_i;
        for (int i = 0; i < 4; i++) begin
            if (merge_en_i && buf_lanes_q[i]) begin
                merge_o[i*8 +: 8] = buf_data_q[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave in front of a single-port DFFRAM. Writes are posted via a
// one-entry buffer so reads and writes both run with zero wait states.
// Build option AHB_SRAM_RAW_FWD_EN: read-after-write hits are forwarded from
// the buffer; without it they stall through DRAIN/REREAD (2 wait states).
//
// state     | meaning
// ST_IDLE   | normal operation, HREADYOUT = 1
// ST_DRAIN  | stalled hazard read, committing any pending buffered write
// ST_REREAD | stalled hazard read, re-issuing the read at the latched address
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-1:0] SRAMADDR
);

    state_t        state_q, state_d;
    logic          wr_dp_q, wr_dp_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]    wr_lanes_q, wr_lanes_d;
    logic          rd_dp_q, rd_dp_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;

    logic          hready_out, acc, acc_rd, acc_wr, hazard, stall_req, fwd_en;
    logic [AW-1:0] a_word;
    logic          buf_v, buf_hit, buf_store, buf_drain;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_lanes;
    logic [31:0]   buf_data, rdata_merged;
    logic          sram_cs;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_wen;
    logic [31:0]   sram_wdata;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    // HRESETn in the accept term keeps the SRAM pins quiet while in reset.
    assign hready_out = (state_q == ST_IDLE);
    assign acc        = HRESETn & HSEL & HTRANS[1] & HREADY & hready_out;
    assign acc_rd     = acc & ~HWRITE;
    assign acc_wr     = acc & HWRITE;
    assign a_word     = HADDR[AW+1:2];
    assign hazard     = acc_rd & (buf_hit | (wr_dp_q & (wr_addr_q == a_word)));

`ifdef AHB_SRAM_RAW_FWD_EN
    logic fwd_q;

    // Remember which read data phase needs buffered bytes overlaid.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) fwd_q <= 1'b0;
        else          fwd_q <= hazard;
    end

    assign fwd_en    = fwd_q;
    assign stall_req = 1'b0;
`else
    assign fwd_en    = 1'b0;
    assign stall_req = hazard;
`endif

    ahb_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .store_i    (buf_store),
        .drain_i    (buf_drain),
        .st_addr_i  (wr_addr_q),
        .st_lanes_i (wr_lanes_q),
        .st_data_i  (HWDATA),
        .cmp_addr_i (a_word),
        .merge_en_i (fwd_en),
        .rdata_i    (SRAMRDATA),
        .valid_o    (buf_v),
        .addr_o     (buf_addr),
        .lanes_o    (buf_lanes),
        .data_o     (buf_data),
        .hit_o      (buf_hit),
        .merge_o    (rdata_merged)
    );

    // State and address/data-phase registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            wr_dp_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_lanes_q <= '0;
            rd_dp_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_dp_q    <= wr_dp_d;
            wr_addr_q  <= wr_addr_d;
            wr_lanes_q <= wr_lanes_d;
            rd_dp_q    <= rd_dp_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Phase tracking; a read data phase persists across stall cycles.
    always_comb begin
        wr_dp_d    = acc_wr;
        wr_addr_d  = acc_wr ? a_word : wr_addr_q;
        wr_lanes_d = acc_wr ? lanes(HSIZE, HADDR[1:0]) : wr_lanes_q;
        rd_dp_d    = hready_out ? acc_rd : rd_dp_q;
        rd_addr_d  = acc_rd ? a_word : rd_addr_q;
    end

    // FSM next state.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = stall_req ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  state_d = ST_REREAD;
            ST_REREAD: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: SRAM port arbitration (read, then drain, then direct write).
    always_comb begin
        sram_cs    = 1'b0;
        sram_addr  = '0;
        sram_wen   = 4'h0;
        sram_wdata = 32'h0;
        buf_store  = 1'b0;
        buf_drain  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_rd && !stall_req) begin
                    sram_cs   = 1'b1;
                    sram_addr = a_word;
                    buf_store = wr_dp_q;
                end else if (buf_v) begin
                    sram_cs    = 1'b1;
                    sram_addr  = buf_addr;
                    sram_wen   = buf_lanes;
                    sram_wdata = buf_data;
                    buf_drain  = 1'b1;
                    buf_store  = wr_dp_q;
                end else if (wr_dp_q) begin
                    sram_cs    = 1'b1;
                    sram_addr  = wr_addr_q;
                    sram_wen   = wr_lanes_q;
                    sram_wdata = HWDATA;
                end
            end
            ST_DRAIN: begin
                if (buf_v) begin
                    sram_cs    = 1'b1;
                    sram_addr  = buf_addr;
                    sram_wen   = buf_lanes;
                    sram_wdata = buf_data;
                    buf_drain  = 1'b1;
                end
            end
            ST_REREAD: begin
                sram_cs   = 1'b1;
                sram_addr = rd_addr_q;
            end
            default: begin
                sram_cs = 1'b0;
            end
        endcase
    end

    assign SRAMCS0   = sram_cs;
    assign SRAMADDR  = sram_addr;
    assign SRAMWEN   = sram_wen;
    assign SRAMWDATA = sram_wdata;
    assign HREADYOUT = hready_out;
    assign HRESP     = 1'b0;
    assign HRDATA    = (rd_dp_q && hready_out) ? rdata_merged : 32'h0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural DFFRAM model.
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    localparam int AW = 15;
`ifdef AHB_SRAM_RAW_FWD_EN
    localparam int EXP_WAITS = 0;
`else
    localparam int EXP_WAITS = 2;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = 32'h0;
    logic [1:0]    HTRANS = 2'b00;
    logic          HWRITE = 1'b0;
    logic [2:0]    HSIZE = 3'd0;
    logic          HREADY;
    logic [31:0]   HWDATA = 32'h0;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [31:0]   SRAMRDATA = 32'h0;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS0;
    logic [AW-1:0] SRAMADDR;

    logic [31:0] mem [0:(1<<AW)-1];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_sram_ctrl #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMADDR  (SRAMADDR)
    );

    // DFFRAM model: Do is registered one cycle after an EN read.
    always @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN == 4'h0) SRAMRDATA <= mem[SRAMADDR];
            for (int i = 0; i < 4; i++) begin
                if (SRAMWEN[i]) mem[SRAMADDR][i*8 +: 8] <= SRAMWDATA[i*8 +: 8];
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive address phase (and HWDATA of the previous one), then settle.
    task automatic cyc(input logic sel, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HSEL   = sel;
        HTRANS = sel ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HWDATA = wdata;
        #1;
    endtask

    initial begin
        int   waits;
        logic done;
        logic saw_wen;

        // Reset values
        #2;
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp",     {31'h0, HRESP},     32'h0);
        chk("rst_cs",        {31'h0, SRAMCS0},   32'h0);
        chk("rst_wen",       {28'h0, SRAMWEN},   32'h0);
        chk("rst_wdata",     SRAMWDATA,          32'h0);
        chk("rst_addr",      {17'h0, SRAMADDR},  32'h0);
        chk("rst_hrdata",    HRDATA,             32'h0);
        cyc(0, 0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // 1: word write then read back
        cyc(1, 1, 32'h100, 3'd2, 32'h0);
        chk("t1_ap_wen", {28'h0, SRAMWEN}, 32'h0);
        cyc(0, 0, 0, 0, 32'hDEADBEEF);
        chk("t1_wen",   {28'h0, SRAMWEN},  32'hF);
        chk("t1_addr",  {17'h0, SRAMADDR}, 32'h40);
        chk("t1_wdata", SRAMWDATA,         32'hDEADBEEF);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 32'h100, 3'd2, 0);
        chk("t1_rd_cs",   {31'h0, SRAMCS0},  32'h1);
        chk("t1_rd_addr", {17'h0, SRAMADDR}, 32'h40);
        cyc(0, 0, 0, 0, 0);
        chk("t1_rdata", HRDATA, 32'hDEADBEEF);
        chk("t1_ready", {31'h0, HREADYOUT}, 32'h1);

        // 2: byte and half writes
        cyc(1, 1, 32'h103, 3'd0, 0);
        cyc(1, 1, 32'h102, 3'd1, 32'hAA000000);
        chk("t2_byte_wen",  {28'h0, SRAMWEN}, 32'h8);
        chk("t2_byte_data", {24'h0, SRAMWDATA[31:24]}, 32'hAA);
        cyc(0, 0, 0, 0, 32'h55660000);
        chk("t2_half_wen", {28'h0, SRAMWEN}, 32'hC);
        cyc(1, 0, 32'h100, 3'd2, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_rdata", HRDATA, 32'h5566BEEF);

        // 3: write then read elsewhere; read wins, buffer drains next idle cycle
        cyc(1, 1, 32'h200, 3'd2, 0);
        cyc(1, 0, 32'h300, 3'd2, 32'hCAFEF00D);
        chk("t3_rd_addr", {17'h0, SRAMADDR}, 32'hC0);
        chk("t3_rd_wen",  {28'h0, SRAMWEN},  32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_drain_wen",   {28'h0, SRAMWEN},  32'hF);
        chk("t3_drain_addr",  {17'h0, SRAMADDR}, 32'h80);
        chk("t3_drain_wdata", SRAMWDATA,         32'hCAFEF00D);
        chk("t3_rd300",       HRDATA,            32'h0);
        cyc(1, 0, 32'h200, 3'd2, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_rd200", HRDATA, 32'hCAFEF00D);

        // 4: read-after-write hazard
        cyc(1, 1, 32'h40, 3'd2, 0);
        cyc(1, 0, 32'h40, 3'd2, 32'h12345678);
        chk("t4_ap_ready", {31'h0, HREADYOUT}, 32'h1);
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (HREADYOUT) done = 1'b1;
            else           waits++;
        end
        chk("t4_waits", waits, EXP_WAITS);
        chk("t4_rdata", HRDATA, 32'h12345678);

        // 5: pending buffer followed by another write
        cyc(1, 1, 32'h10, 3'd2, 0);
        cyc(1, 0, 32'h20, 3'd2, 32'h11111111);
        cyc(1, 1, 32'h14, 3'd2, 0);
        chk("t5_drain_addr", {17'h0, SRAMADDR}, 32'h4);
        chk("t5_drain_wen",  {28'h0, SRAMWEN},  32'hF);
        chk("t5_rd20",       HRDATA,            32'h0);
        cyc(0, 0, 0, 0, 32'h22222222);
        chk("t5_wr_addr", {17'h0, SRAMADDR}, 32'h5);
        cyc(1, 0, 32'h10, 3'd2, 0);
        cyc(1, 0, 32'h14, 3'd2, 0);
        chk("t5_rd10", HRDATA, 32'h11111111);
        cyc(0, 0, 0, 0, 0);
        chk("t5_rd14", HRDATA, 32'h22222222);

        // 6: reset while the buffer holds a write
        cyc(1, 1, 32'h30, 3'd2, 0);
        cyc(1, 0, 32'h300, 3'd2, 32'h99999999);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HTRANS  = HTRANS_IDLE;
        HWRITE  = 1'b0;
        HADDR   = 32'h0;
        HWDATA  = 32'h0;
        #1;
        chk("t6_cs",        {31'h0, SRAMCS0},   32'h0);
        chk("t6_wen",       {28'h0, SRAMWEN},   32'h0);
        chk("t6_wdata",     SRAMWDATA,          32'h0);
        chk("t6_addr",      {17'h0, SRAMADDR},  32'h0);
        chk("t6_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        saw_wen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (SRAMWEN != 4'h0) saw_wen = 1'b1;
        end
        chk("t6_no_wen", {31'h0, saw_wen}, 32'h0);
        cyc(1, 0, 32'h30, 3'd2, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_discarded", HRDATA, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
